// File: rtl/rng_arbiter_pkg.sv
// rng_arbiter_pkg
//   Shared definitions for the RNG arbiter slice: FSM state encoding and
//   default parameter values.
package rng_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RNG = 2'd1,
        DELIVER  = 2'd2,
        COOL     = 2'd3
    } state_t;

    localparam int DEFAULT_NUM_REQ      = 4;
    localparam int DEFAULT_OUTPUT_WIDTH = 8;
    localparam int DEFAULT_TIMEOUT      = 64;

endpackage

// File: rtl/rng_arbiter_if.sv
// rng_arbiter_if
//   Bundles the client-side request/response signals and the shared-RNG
//   handshake of the arbiter.
//   Client side : req (in), grant, word_out, word_valid, err, busy (out)
//   RNG side    : rng_word, rng_valid (in), rng_en (out)
//   modport slave  - arbiter view
//   modport master - environment view (clients + RNG)
interface rng_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int OUTPUT_WIDTH = 8
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      grant;
    logic [OUTPUT_WIDTH-1:0] word_out;
    logic [NUM_REQ-1:0]      word_valid;
    logic [NUM_REQ-1:0]      err;
    logic                    busy;
    logic                    rng_en;
    logic [OUTPUT_WIDTH-1:0] rng_word;
    logic                    rng_valid;

    modport slave (
        input  req, rng_word, rng_valid,
        output grant, word_out, word_valid, err, busy, rng_en
    );

    modport master (
        output req, rng_word, rng_valid,
        input  grant, word_out, word_valid, err, busy, rng_en
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin selector.
//   req    : per-client request vector
//   last   : index of the most recently granted client
//   winner : one-hot pick, first set request strictly after 'last',
//            wrapping from NUM_REQ-1 back to 0
//   any    : at least one request pending
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic               any
);

    logic [NUM_REQ-1:0] win_hi;
    logic [NUM_REQ-1:0] win_lo;
    logic               found_hi;
    logic               found_lo;

    // Two passes instead of a rotate: the "above last" pass has priority,
    // the unrestricted pass covers the wrap-around (including 'last' itself).
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_hi && req[i] && (i > int'(last))) begin
                win_hi[i] = 1'b1;
                found_hi  = 1'b1;
            end
            if (!found_lo && req[i]) begin
                win_lo[i] = 1'b1;
                found_lo  = 1'b1;
            end
        end
    end

    assign winner = found_hi ? win_hi : win_lo;
    assign any    = |req;

endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter
//   Arbitrates NUM_REQ clients for one shared RNG. A round-robin winner is
//   granted, the RNG is enabled until it returns a word (or the owner gives
//   up, or TIMEOUT expires), the word is handed to the owner for one cycle,
//   and the RNG gets one extra enable cycle (COOL) to clear its state.
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous active-high reset
//     bus   - rng_arbiter_if.slave (client request/response + RNG handshake)
module rng_arbiter
    import rng_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    rng_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [NUM_REQ-1:0]      grant_q;
    logic [NUM_REQ-1:0]      err_q;
    logic [IDX_W-1:0]        last_q;
    logic [OUTPUT_WIDTH-1:0] cap_q;
    logic [TMR_W-1:0]        timer_q;

    logic [NUM_REQ-1:0]      win;
    logic [IDX_W-1:0]        win_idx;
    logic                    any_req;
    logic                    abandon;
    logic                    timeout_hit;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (bus.req),
        .last   (last_q),
        .winner (win),
        .any    (any_req)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = IDX_W'(i);
        end
    end

    // Owner gave up: its req bit is no longer set.
    assign abandon     = ~|(bus.req & grant_q);
    assign timeout_hit = (timer_q == TMR_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state. In WAIT_RNG: abandon beats rng_valid, rng_valid beats timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_req) state_nxt = WAIT_RNG;
            WAIT_RNG: begin
                if (abandon)            state_nxt = COOL;
                else if (bus.rng_valid) state_nxt = DELIVER;
                else if (timeout_hit)   state_nxt = COOL;
            end
            DELIVER:  state_nxt = COOL;
            COOL:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath: grant, round-robin pointer, timer, captured word, err pulse.
    // last_q resets to NUM_REQ-1 so the first search begins at index 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            err_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cap_q   <= '0;
            timer_q <= '0;
        end else begin
            err_q <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= win;
                        last_q  <= win_idx;
                        timer_q <= '0;
                    end
                end
                WAIT_RNG: begin
                    if (timer_q != '1) timer_q <= timer_q + 1'b1;
                    if (abandon)            grant_q <= '0;
                    else if (bus.rng_valid) cap_q   <= bus.rng_word;
                    else if (timeout_hit)   err_q   <= grant_q;
                end
                DELIVER: cap_q   <= '0;
                COOL:    grant_q <= '0;
                default: ;
            endcase
        end
    end

    // Outputs decode from reset-cleared registers, so reset zeroes them at once.
    assign bus.grant      = grant_q;
    assign bus.err        = err_q;
    assign bus.word_valid = (state == DELIVER) ? grant_q : '0;
    assign bus.word_out   = (state == DELIVER) ? cap_q : '0;
    assign bus.rng_en     = (state == WAIT_RNG) || (state == COOL);
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
module tb_rng_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    rng_arbiter_if #(.NUM_REQ(4), .OUTPUT_WIDTH(8)) bus ();

    rng_arbiter #(.NUM_REQ(4), .OUTPUT_WIDTH(8), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.req = 4'b0000; bus.rng_valid = 1'b0; bus.rng_word = 8'h00;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        bus.req = 4'b0000; bus.rng_valid = 1'b0; bus.rng_word = 8'h00;
        reset = 1'b1;
        repeat (2) tick;
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
        checks++; if (bus.word_out !== 8'h00 || bus.word_valid !== 4'b0000) begin errors++; $display("FAIL reset_word got=%h/%b exp=00/0000", bus.word_out, bus.word_valid); end
        checks++; if (bus.err !== 4'b0000 || bus.rng_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_ctl err=%b rng_en=%b busy=%b exp=0000/0/0", bus.err, bus.rng_en, bus.busy); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single;
        bus.req = 4'b0001;
        tick; // grant loaded, WAIT_RNG cycle 1
        checks++; if (bus.grant !== 4'b0001 || bus.rng_en !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_grant grant=%b rng_en=%b busy=%b exp=0001/1/1", bus.grant, bus.rng_en, bus.busy); end
        tick; // WAIT_RNG cycle 2
        tick; // WAIT_RNG cycle 3
        checks++; if (bus.word_valid !== 4'b0000) begin errors++; $display("FAIL single_early_valid got=%b exp=0000", bus.word_valid); end
        bus.rng_valid = 1'b1; bus.rng_word = 8'hA5;
        tick; // DELIVER
        bus.rng_valid = 1'b0; bus.rng_word = 8'h00; bus.req = 4'b0000;
        checks++; if (bus.word_valid !== 4'b0001 || bus.word_out !== 8'hA5) begin errors++; $display("FAIL single_deliver got=%b/%h exp=0001/a5", bus.word_valid, bus.word_out); end
        tick; // COOL
        checks++; if (bus.word_valid !== 4'b0000 || bus.word_out !== 8'h00 || bus.rng_en !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_cool wv=%b wo=%h rng_en=%b busy=%b exp=0000/00/1/1", bus.word_valid, bus.word_out, bus.rng_en, bus.busy); end
        tick; // IDLE
        checks++; if (bus.grant !== 4'b0000 || bus.rng_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle grant=%b rng_en=%b busy=%b exp=0000/0/0", bus.grant, bus.rng_en, bus.busy); end
    endtask

    task automatic test_fairness;
        int         cnt [4];
        logic [3:0] oh;
        logic [7:0] w;
        cnt = '{0, 0, 0, 0};
        do_reset;
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << (n % 4);
            w  = 8'h10 + 8'(n);
            tick;
            checks++; if (bus.grant !== oh) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", n, bus.grant, oh); end
            bus.rng_valid = 1'b1; bus.rng_word = w;
            tick;
            bus.rng_valid = 1'b0;
            checks++; if (bus.word_valid !== oh || bus.word_out !== w) begin errors++; $display("FAIL fair_word%0d got=%b/%h exp=%b/%h", n, bus.word_valid, bus.word_out, oh, w); end
            for (int i = 0; i < 4; i++) if (bus.word_valid[i]) cnt[i]++;
            tick; // COOL
            tick; // IDLE
        end
        bus.req = 4'b0000;
        checks++; if (cnt[0] != 2 || cnt[1] != 1 || cnt[2] != 1 || cnt[3] != 1) begin errors++; $display("FAIL fair_count got=%0d,%0d,%0d,%0d exp=2,1,1,1", cnt[0], cnt[1], cnt[2], cnt[3]); end
        tick;
    endtask

    task automatic test_timeout;
        logic bad;
        bad = 1'b0;
        bus.req = 4'b0100;
        tick; // grant
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL to_grant got=%b exp=0100", bus.grant); end
        for (int k = 1; k < 8; k++) begin
            tick;
            if (bus.err !== 4'b0000 || bus.word_valid !== 4'b0000 || bus.rng_en !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL to_early got=err_or_valid_before_8 exp=quiet_wait"); end
        tick; // 8 cycles after grant
        checks++; if (bus.err !== 4'b0100 || bus.word_valid !== 4'b0000) begin errors++; $display("FAIL to_err got=%b/%b exp=0100/0000", bus.err, bus.word_valid); end
        bus.req = 4'b0000;
        tick; // IDLE
        checks++; if (bus.err !== 4'b0000 || bus.rng_en !== 1'b0 || bus.grant !== 4'b0000) begin errors++; $display("FAIL to_after err=%b rng_en=%b grant=%b exp=0000/0/0000", bus.err, bus.rng_en, bus.grant); end
    endtask

    task automatic test_abandon;
        bus.req = 4'b1001;
        tick; // grant to client 3 (pointer after client 2)
        checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL ab_grant got=%b exp=1000", bus.grant); end
        tick;
        bus.req = 4'b0001; bus.rng_valid = 1'b1; bus.rng_word = 8'h3C;
        tick; // COOL
        bus.rng_valid = 1'b0; bus.rng_word = 8'h00;
        checks++; if (bus.word_valid !== 4'b0000 || bus.err !== 4'b0000 || bus.grant !== 4'b0000 || bus.rng_en !== 1'b1) begin errors++; $display("FAIL ab_cool wv=%b err=%b grant=%b rng_en=%b exp=0000/0000/0000/1", bus.word_valid, bus.err, bus.grant, bus.rng_en); end
        tick; // IDLE
        tick; // grant client 0
        checks++; if (bus.grant !== 4'b0001 || bus.word_out !== 8'h00) begin errors++; $display("FAIL ab_next got=%b/%h exp=0001/00", bus.grant, bus.word_out); end
        bus.rng_valid = 1'b1; bus.rng_word = 8'h77;
        tick; // DELIVER
        bus.rng_valid = 1'b0; bus.req = 4'b0000;
        checks++; if (bus.word_valid !== 4'b0001 || bus.word_out !== 8'h77) begin errors++; $display("FAIL ab_word got=%b/%h exp=0001/77", bus.word_valid, bus.word_out); end
        tick; // COOL
        tick; // IDLE
    endtask

    task automatic test_reset_mid;
        bus.req = 4'b0100;
        tick;
        tick;
        checks++; if (bus.rng_en !== 1'b1 || bus.grant !== 4'b0100) begin errors++; $display("FAIL rm_pre rng_en=%b grant=%b exp=1/0100", bus.rng_en, bus.grant); end
        reset = 1'b1;
        #1;
        checks++; if (bus.rng_en !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.word_valid !== 4'b0000 || bus.word_out !== 8'h00 || bus.err !== 4'b0000) begin errors++; $display("FAIL rm_async rng_en=%b grant=%b busy=%b exp=0/0000/0", bus.rng_en, bus.grant, bus.busy); end
        tick;
        reset = 1'b0;
        bus.req = 4'b1001;
        tick;
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL rm_first got=%b exp=0001", bus.grant); end
        bus.rng_valid = 1'b1; bus.rng_word = 8'h5A;
        tick; // DELIVER
        bus.rng_valid = 1'b0; bus.req = 4'b1000;
        checks++; if (bus.word_valid !== 4'b0001 || bus.word_out !== 8'h5A) begin errors++; $display("FAIL rm_word got=%b/%h exp=0001/5a", bus.word_valid, bus.word_out); end
        tick; // COOL
        tick; // IDLE
        tick;
        checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL rm_second got=%b exp=1000", bus.grant); end
        bus.req = 4'b0000;
        tick; // abandon -> COOL
        tick; // IDLE
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_idle busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_spurious;
        logic bad;
        bad = 1'b0;
        bus.rng_valid = 1'b1; bus.rng_word = 8'hEE;
        repeat (3) begin
            tick;
            if (bus.word_valid !== 4'b0000 || bus.word_out !== 8'h00 || bus.busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL sp_idle got=activity_in_idle exp=none"); end
        bus.rng_valid = 1'b0;
        bus.req = 4'b0010;
        tick;
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL sp_grant got=%b exp=0010", bus.grant); end
        bus.rng_valid = 1'b1; bus.rng_word = 8'h11;
        tick; // DELIVER
        checks++; if (bus.word_valid !== 4'b0010 || bus.word_out !== 8'h11) begin errors++; $display("FAIL sp_word got=%b/%h exp=0010/11", bus.word_valid, bus.word_out); end
        bus.req = 4'b0000; bus.rng_word = 8'hEE;
        tick; // COOL, rng_valid still high
        checks++; if (bus.word_valid !== 4'b0000 || bus.word_out !== 8'h00) begin errors++; $display("FAIL sp_cool got=%b/%h exp=0000/00", bus.word_valid, bus.word_out); end
        tick; // IDLE
        tick;
        bus.rng_valid = 1'b0;
        checks++; if (bus.word_valid !== 4'b0000 || bus.word_out !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL sp_after got=%b/%h busy=%b exp=0000/00/0", bus.word_valid, bus.word_out, bus.busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req = 4'b0000; bus.rng_valid = 1'b0; bus.rng_word = 8'h00;
        test_reset;
        test_single;
        test_fairness;
        test_timeout;
        test_abandon;
        test_reset_mid;
        test_spurious;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
